// File: rtl/sdr_pkg.sv
// Shared types and constants for the SDR measurement-window scheduler.
package sdr_pkg;

    localparam int RESULT_W         = 24;
    localparam int BYTES_PER_RESULT = 3;
    localparam int BYTE_IDX_W       = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        MAC,
        SEND
    } win_state_t;

endpackage

// File: rtl/sdr_byte_serializer.sv
// Streams a latched 24-bit result as LSB-first bytes over a valid/ready port.
module sdr_byte_serializer
    import sdr_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [RESULT_W-1:0] load_word,
    input  logic                flush,
    input  logic                out_ready,
    output logic [7:0]          out_byte,
    output logic                out_valid,
    output logic                out_last,
    output logic                done
);

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_RESULT - 1);

    logic [RESULT_W-1:0]   word_q, word_d;
    logic [BYTE_IDX_W-1:0] idx_q, idx_d, idx_nxt;
    logic [7:0]            byte_q, byte_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  handshake;

    always_comb begin
        word_d    = word_q;
        idx_d     = idx_q;
        byte_d    = byte_q;
        valid_d   = valid_q;
        last_d    = last_q;
        idx_nxt   = idx_q + 1'b1;
        handshake = valid_q & out_ready;
        done      = handshake & last_q;

        if (flush) begin
            idx_d   = '0;
            byte_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else if (load) begin
            word_d  = load_word;
            idx_d   = '0;
            byte_d  = load_word[7:0];
            valid_d = 1'b1;
            last_d  = (LAST_IDX == '0);
        end else if (handshake) begin
            if (last_q) begin
                idx_d   = '0;
                byte_d  = '0;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end else begin
                // Byte register is preloaded so out_byte stays a plain flop output.
                idx_d  = idx_nxt;
                byte_d = 8'(word_q >> {idx_nxt, 3'b000});
                last_d = (idx_nxt == LAST_IDX);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q  <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            word_q  <= word_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign out_byte  = byte_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;

endmodule

// File: rtl/sdr_window_sched.sv
// Measurement-window scheduler: clear, accumulate, MAC trigger, byte-serialised result.
// Define SDR_WIN_SAT_EN to saturate oversized MAC sums instead of truncating them.
module sdr_window_sched
    import sdr_pkg::*;
#(
    parameter int WINDOW_LEN  = 256,
    parameter int MAC_TIMEOUT = 15,
    parameter int SUM_W       = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic             abort,
    output logic             dp_clear,
    output logic             dp_count_en,
    output logic             mac_start,
    input  logic             mac_valid,
    input  logic [SUM_W-1:0] mac_sum,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             err_timeout
);

    localparam int WIN_CNT_W = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
    localparam int TO_CNT_W  = (MAC_TIMEOUT > 1) ? $clog2(MAC_TIMEOUT) : 1;
    localparam logic [WIN_CNT_W-1:0] WIN_LAST = WIN_CNT_W'(WINDOW_LEN - 1);
    localparam logic [TO_CNT_W-1:0]  TO_LAST  = TO_CNT_W'(MAC_TIMEOUT - 1);

    function automatic logic [RESULT_W-1:0] fit_result(input logic [SUM_W-1:0] sum);
`ifdef SDR_WIN_SAT_EN
        if ((sum >> RESULT_W) != '0) begin
            return '1;
        end
`endif
        return RESULT_W'(sum);
    endfunction

    win_state_t           state_q, state_d;
    logic [WIN_CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic [TO_CNT_W-1:0]  to_cnt_q, to_cnt_d;
    logic                 err_timeout_q, err_timeout_d;
    logic                 dp_clear_q, dp_clear_d;
    logic                 dp_count_en_q, dp_count_en_d;
    logic                 mac_start_q, mac_start_d;
    logic                 busy_q, busy_d;
    logic                 ser_load;
    logic                 ser_done;

    always_comb begin
        state_d       = state_q;
        win_cnt_d     = win_cnt_q;
        to_cnt_d      = to_cnt_q;
        err_timeout_d = err_timeout_q;
        ser_load      = 1'b0;

        if (abort) begin
            state_d   = IDLE;
            win_cnt_d = '0;
            to_cnt_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d       = CLEAR;
                        err_timeout_d = 1'b0;
                    end
                end
                CLEAR: begin
                    state_d   = ACCUM;
                    win_cnt_d = '0;
                end
                ACCUM: begin
                    if (win_cnt_q == WIN_LAST) begin
                        state_d   = MAC;
                        win_cnt_d = '0;
                        to_cnt_d  = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                    end
                end
                MAC: begin
                    if (mac_valid) begin
                        ser_load = 1'b1;
                        state_d  = SEND;
                        to_cnt_d = '0;
                    end else if (to_cnt_q == TO_LAST) begin
                        err_timeout_d = 1'b1;
                        state_d       = IDLE;
                        to_cnt_d      = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
                SEND: begin
                    if (ser_done) begin
                        state_d = cont ? CLEAR : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Strobes are decoded from the next state so every output leaves a flop.
        dp_clear_d    = (state_d == CLEAR);
        dp_count_en_d = (state_d == ACCUM);
        mac_start_d   = (state_d == MAC) && (state_q != MAC);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            win_cnt_q     <= '0;
            to_cnt_q      <= '0;
            err_timeout_q <= 1'b0;
            dp_clear_q    <= 1'b0;
            dp_count_en_q <= 1'b0;
            mac_start_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            win_cnt_q     <= win_cnt_d;
            to_cnt_q      <= to_cnt_d;
            err_timeout_q <= err_timeout_d;
            dp_clear_q    <= dp_clear_d;
            dp_count_en_q <= dp_count_en_d;
            mac_start_q   <= mac_start_d;
            busy_q        <= busy_d;
        end
    end

    sdr_byte_serializer u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ser_load),
        .load_word (fit_result(mac_sum)),
        .flush     (abort),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_last  (out_last),
        .done      (ser_done)
    );

    assign dp_clear    = dp_clear_q;
    assign dp_count_en = dp_count_en_q;
    assign mac_start   = mac_start_q;
    assign busy        = busy_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_sdr_window_sched.sv
// Scoreboard bench for sdr_window_sched (WINDOW_LEN=4), with a behavioural MAC responder.
module tb_sdr_window_sched;

    localparam int WL = 4;
    localparam int TO = 15;
    localparam int SW = 25;

    logic          clk = 1'b0;
    logic          rst_n, start, cont, abort;
    logic          dp_clear, dp_count_en, mac_start, mac_valid;
    logic [SW-1:0] mac_sum;
    logic [7:0]    out_byte;
    logic          out_valid, out_ready, out_last, busy, err_timeout;

    always #5 clk = ~clk;

    sdr_window_sched #(.WINDOW_LEN(WL), .MAC_TIMEOUT(TO), .SUM_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
        .dp_clear(dp_clear), .dp_count_en(dp_count_en), .mac_start(mac_start),
        .mac_valid(mac_valid), .mac_sum(mac_sum),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .err_timeout(err_timeout)
    );

    int          n_chk = 0;
    int          n_bad = 0;
    logic [8:0]  exp_q[$];
    int          hs_cnt = 0;
    int          last_cnt = 0;
    logic        ov_seen = 1'b0;
    logic        clr_pend = 1'b0;
    logic        clr_exp = 1'b0;
    logic        mac_en = 1'b1;
    int          mac_lat = 2;
    int          rsp_n = 0;
    logic [24:0] mac_vals[4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] exp_result(input logic [24:0] v);
`ifdef SDR_WIN_SAT_EN
        if (v[24]) return 24'hFFFFFF;
`endif
        return v[23:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            tick();
            n++;
        end
        check_eq("wait_valid", out_valid, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check_eq("wait_idle", busy, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {dp_clear, dp_count_en, mac_start, out_valid, out_last, busy, err_timeout, out_byte}, 0);
    endtask

    // MAC responder: answers each mac_start after mac_lat cycles and records the expected bytes.
    initial begin
        logic [24:0] v;
        logic [23:0] r;
        mac_valid = 1'b0;
        mac_sum   = '0;
        forever begin
            @(negedge clk);
            if (mac_start && mac_en && rst_n) begin
                repeat (mac_lat) @(posedge clk);
                #1;
                v = mac_vals[rsp_n % 4];
                rsp_n++;
                mac_sum   = v;
                mac_valid = 1'b1;
                r = exp_result(v);
                for (int b = 0; b < 3; b++) exp_q.push_back({(b == 2), r[8*b +: 8]});
                @(posedge clk);
                #1;
                mac_valid = 1'b0;
            end
        end
    end

    // Output monitor: compares every accepted byte against the scoreboard.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (clr_pend) begin
                check_eq("clr_after_last", dp_clear, clr_exp);
                clr_pend = 1'b0;
            end
            if (out_valid) ov_seen = 1'b1;
            if (rst_n && !abort && out_valid && out_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("extra_byte", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("byte", out_byte, e[7:0]);
                    check_eq("last", out_last, e[8]);
                end
                if (out_last) begin
                    last_cnt++;
                    clr_pend = 1'b1;
                    clr_exp  = cont;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0, l0, n;
        mac_vals = '{25'h0ABCDEF, 25'h1000001, 25'h0123456, 25'h1FFFFFF};
        rst_n = 1'b0; start = 1'b0; cont = 1'b0; abort = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        tick();
        check_all_zero("idle_after_reset");

        // Basic window: strobe timing and three bytes EF, CD, AB.
        rsp_n = 0;
        hs0 = hs_cnt;
        pulse_start();
        check_eq("clear_cyc", {dp_clear, dp_count_en, busy}, 3'b101);
        for (int i = 0; i < WL; i++) begin
            tick();
            check_eq("accum_cyc", {dp_clear, dp_count_en, mac_start}, 3'b010);
        end
        tick();
        check_eq("mac_start_cyc", {dp_count_en, mac_start}, 2'b01);
        tick();
        check_eq("mac_start_once", mac_start, 0);
        wait_idle(100);
        check_eq("basic_hs", hs_cnt - hs0, 3);
        check_eq("basic_q_empty", exp_q.size(), 0);
        check_eq("basic_ov_low", out_valid, 0);

        // Backpressure on byte 1.
        rsp_n = 0;
        out_ready = 1'b0;
        hs0 = hs_cnt;
        pulse_start();
        wait_valid(100);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_hold", {out_valid, out_byte}, {1'b1, mac_vals[0][15:8]});
            tick();
        end
        out_ready = 1'b1;
        wait_idle(100);
        check_eq("bp_hs", hs_cnt - hs0, 3);

        // Continuous mode: three back-to-back windows from one start.
        rsp_n = 1;
        cont = 1'b1;
        l0 = last_cnt;
        hs0 = hs_cnt;
        pulse_start();
        n = 0;
        while (last_cnt < l0 + 2 && n < 300) begin
            tick();
            n++;
        end
        cont = 1'b0;
        wait_idle(200);
        check_eq("cont_windows", last_cnt - l0, 3);
        check_eq("cont_hs", hs_cnt - hs0, 9);
        check_eq("cont_q_empty", exp_q.size(), 0);

        // MAC timeout.
        mac_en = 1'b0;
        ov_seen = 1'b0;
        pulse_start();
        n = 0;
        while (!mac_start && n < 100) begin
            tick();
            n++;
        end
        check_eq("to_mac_start", mac_start, 1);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check_eq("to_cycles", n, TO);
        check_eq("to_err_idle", {err_timeout, busy}, 2'b10);
        check_eq("to_no_output", ov_seen, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("to_err_kept_abort", err_timeout, 1);
        mac_en = 1'b1;
        rsp_n = 0;
        pulse_start();
        check_eq("to_err_cleared", err_timeout, 0);
        wait_idle(100);

        // Abort mid-ACCUM (cycle 2 of 4).
        pulse_start();
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_accum", {dp_clear, dp_count_en, mac_start, out_valid, busy}, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("abort_quiet", {mac_start, busy, dp_count_en}, 0);
        end

        // Abort mid-SEND at byte 1.
        rsp_n = 0;
        out_ready = 1'b0;
        pulse_start();
        wait_valid(100);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("abort_send_byte1", out_byte, mac_vals[0][15:8]);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        check_eq("abort_send", {out_valid, out_last, busy, out_byte}, 0);
        hs0 = hs_cnt;
        out_ready = 1'b1;
        repeat (5) tick();
        check_eq("abort_no_bytes", hs_cnt - hs0, 0);

        // Oversized MAC sum: saturation or truncation depending on build.
        rsp_n = 1;
        hs0 = hs_cnt;
        pulse_start();
        wait_valid(100);
`ifdef SDR_WIN_SAT_EN
        check_eq("sat_byte0", out_byte, 8'hFF);
`else
        check_eq("trunc_byte0", out_byte, 8'h01);
`endif
        wait_idle(100);
        check_eq("sat_hs", hs_cnt - hs0, 3);

        // Reset during SEND.
        rsp_n = 0;
        out_ready = 1'b0;
        pulse_start();
        wait_valid(100);
        rst_n = 1'b0;
        tick();
        check_all_zero("reset_mid_send");
        rst_n = 1'b1;
        exp_q.delete();
        out_ready = 1'b1;
        tick();
        check_all_zero("after_reset_send");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/sdr_window_sched.md
# sdr_window_sched

Measurement-window scheduler for the I/Q constellation-correlation datapath. It clears the density-matrix counters and enables them for a fixed sample window. It then triggers the 4x4 multiply-accumulate, latches the resulting sum, and streams it out as bytes over a valid/ready port. In continuous mode it re-arms automatically so windows repeat back-to-back.

## Interface
- WINDOW_LEN, 256: samples counted per window (≥1)
- MAC_TIMEOUT, 15: max cycles to wait for mac_valid after mac_start
- SUM_W, 25: width of incoming MAC sum
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  single-shot window request (level sampled in IDLE)
- cont  in  1  continuous mode; re-arm after each result is sent
- abort  in  1  return to IDLE at next edge; discards result
- dp_clear  out  1  clear density-matrix counters
- dp_count_en  out  1  enable counting of current sample
- mac_start  out  1  one-cycle MAC trigger
- mac_valid  in  1  MAC result valid
- mac_sum  in  SUM_W  MAC result
- out_byte  out  8  result byte, LSB first
- out_valid  out  1  byte available
- out_ready  in  1  sink accepts byte when out_valid & out_ready
- out_last  out  1  marks third (final) byte
- busy  out  1  state ≠ IDLE
- err_timeout  out  1  sticky; MAC failed to respond

## Operation
- States: IDLE, CLEAR, ACCUM, MAC, SEND.
- IDLE: all strobes low. start=1 → CLEAR.
- CLEAR: dp_clear=1 for exactly 1 cycle → ACCUM. Sample counter loads 0.
- ACCUM: dp_count_en=1 for exactly WINDOW_LEN cycles. Counter wraps to 0 on exit → MAC.
- MAC: mac_start=1 on the first cycle only, and the wait counter starts.
  - mac_valid=1 → latch result into a 24-bit register → SEND with byte index 0.
  - Wait counter reaches MAC_TIMEOUT without mac_valid → set err_timeout → IDLE. No output is produced.
- Result width: mac_sum truncated to bits [23:0]; see Configuration for saturation.
- SEND: out_valid=1 and out_byte=result[8·idx+7 : 8·idx], idx = 0, 1, 2. out_last=1 when idx=2.
  - idx advances only on handshake; out_byte holds stable while out_valid & !out_ready.
  - After the idx=2 handshake: cont=1 → CLEAR; cont=0 → IDLE.
- abort has priority over every transition. Any state → IDLE on the next edge, and all strobes drop that cycle. err_timeout is not cleared by abort.
- err_timeout clears only on reset or when start is accepted in IDLE.
- start while busy: ignored, not queued.
- mac_valid outside MAC: ignored.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, result 0, err_timeout 0.
- start sampled at edge t → dp_clear high during cycle t+1 → dp_count_en high for cycles t+2 … t+1+WINDOW_LEN.
- mac_start is high in cycle t+2+WINDOW_LEN.
- mac_valid seen at edge m → out_valid high from cycle m+1.
- Minimum window period in cont mode with out_ready=1: WINDOW_LEN + 1 + 3 + MAC latency + 1 cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- SDR_WIN_SAT_EN defined: a mac_sum value exceeding 24 bits is saturated to 24'hFFFFFF. Truncation is not applied.
- SDR_WIN_SAT_EN undefined: plain truncation to [23:0].

## Structure
- Shared package sdr_pkg holds:
  - state enum win_state_t;
  - constants RESULT_W=24, BYTES_PER_RESULT=3.
- One sub-module: sdr_byte_serializer. It loads the 24-bit word and handles the valid/ready byte stream, index and out_last.
- The FSM, window counter and timeout counter stay in the top.

## Test plan
- WINDOW_LEN=4, start pulse: dp_clear 1 cycle, then dp_count_en exactly 4 cycles, then mac_start 1 cycle. MAC returns 25'h0ABCDEF after 2 cycles → bytes EF, CD, AB, with out_last on AB, then IDLE and busy=0.
- Backpressure: out_ready low for 5 cycles on byte 1 → out_byte stays CD and out_valid stays high; exactly 3 handshakes total.
- cont=1, out_ready=1: three consecutive windows; dp_clear follows each out_last handshake by 1 cycle; no start required after the first.
- No mac_valid: err_timeout=1 after MAC_TIMEOUT cycles, state IDLE, out_valid never asserted. Next start clears err_timeout.
- abort asserted mid-ACCUM (cycle 2 of 4) and mid-SEND (byte 1): next cycle all strobes 0, busy=0, no further bytes.
- mac_sum=25'h1000001: with SDR_WIN_SAT_EN → FF, FF, FF; without → 01, 00, 00. Reset asserted mid-SEND → all outputs 0 at next edge.
